// File: rtl/gate2_bist.sv
// Stimulus/response checker for a 2-input combinational gate: sweeps {a,b} through
// 00,01,10,11 and compares the gate output against the truth table chosen at start.
module gate2_bist #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       func_sel,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2:0]       fail_vec
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PW-1:0] LAST_PASS   = PW'(PASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    state_t           w_first;
    logic [2:0]       r_sel;
    logic [1:0]       r_idx;
    logic [PW-1:0]    r_pcnt;
    logic [SW-1:0]    r_settle;
    logic [CNT_W-1:0] r_err;
    logic             r_fv;
    logic [2:0]       r_fvec;
    logic             r_pass;
    logic             w_exp;
    logic             w_mis;
    logic             w_last;
    logic [CNT_W-1:0] w_err_next;

    assign w_first = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
    assign w_last  = (r_idx == 2'd3) && (r_pcnt == LAST_PASS);

    always_comb begin
        w_exp = 1'b0;
        case (r_sel)
            3'd0:    w_exp = r_idx[1] & r_idx[0];
            3'd1:    w_exp = r_idx[1] | r_idx[0];
            3'd2:    w_exp = r_idx[1] ^ r_idx[0];
            3'd3:    w_exp = ~(r_idx[1] & r_idx[0]);
            3'd4:    w_exp = ~(r_idx[1] | r_idx[0]);
            3'd5:    w_exp = ~(r_idx[1] ^ r_idx[0]);
            3'd6:    w_exp = r_idx[1];
            default: w_exp = ~r_idx[1];
        endcase
    end

    assign w_mis      = (dut_y != w_exp);
    assign w_err_next = (w_mis && (r_err != '1)) ? r_err + CNT_W'(1) : r_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = w_first;
            S_SETTLE:       if (r_settle == '0) w_next = S_SAMPLE;
            S_SAMPLE:       w_next = w_last ? S_DONE : w_first;
            default:        w_next = S_IDLE;
        endcase
    end

    // The pattern index doubles as the registered stimulus; it wraps to 00 on the
    // final sample, so the gate inputs return to 0 in DONE without extra logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel    <= '0;
            r_idx    <= '0;
            r_pcnt   <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_fv     <= 1'b0;
            r_fvec   <= '0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_sel    <= func_sel;
                        r_idx    <= '0;
                        r_pcnt   <= '0;
                        r_settle <= SETTLE_LOAD;
                        r_err    <= '0;
                        r_fv     <= 1'b0;
                        r_fvec   <= '0;
                        r_pass   <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (r_settle != '0) r_settle <= r_settle - SW'(1);
                end
                S_SAMPLE: begin
                    r_err    <= w_err_next;
                    r_settle <= SETTLE_LOAD;
                    r_idx    <= r_idx + 2'd1;
                    if (w_mis && !r_fv) begin
                        r_fv   <= 1'b1;
                        r_fvec <= {r_idx[1], r_idx[0], dut_y};
                    end
                    if (w_last) r_pass <= (w_err_next == '0);
                    else if (r_idx == 2'd3) r_pcnt <= r_pcnt + PW'(1);
                end
                default: ;
            endcase
        end
    end

    assign dut_a      = r_idx[1];
    assign dut_b      = r_idx[0];
    assign busy       = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fv;
    assign fail_vec   = r_fvec;

endmodule

// File: tb/tb_gate2_bist.sv
// Directed bench for gate2_bist: four instances (default, PASSES=4, SETTLE=0, SETTLE=2)
// each checking a behavioural gate model selected per run.
module tb_gate2_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] func_sel;
    logic [3:0] start_v;
    logic [3:0] a_v, b_v, y_v, busy_v, done_v, pass_v, fv_v;
    logic [2:0] err_v [4];
    logic [2:0] vec_v [4];
    logic [1:0] mode_v [4];
    logic [1:0] ab_log [64];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // mode 0: OR gate, 1: stuck-at-0, 2: stuck-at-1, 3: XOR gate
    function automatic logic gate(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return a | b;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return a ^ b;
        endcase
    endfunction

    assign y_v[0] = gate(mode_v[0], a_v[0], b_v[0]);
    assign y_v[1] = gate(mode_v[1], a_v[1], b_v[1]);
    assign y_v[2] = gate(mode_v[2], a_v[2], b_v[2]);
    assign y_v[3] = gate(mode_v[3], a_v[3], b_v[3]);

    gate2_bist #(.SETTLE_CYCLES(1), .PASSES(1), .CNT_W(3)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .func_sel(func_sel),
        .dut_a(a_v[0]), .dut_b(b_v[0]), .dut_y(y_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_count(err_v[0]), .fail_valid(fv_v[0]), .fail_vec(vec_v[0]));

    gate2_bist #(.SETTLE_CYCLES(1), .PASSES(4), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .func_sel(func_sel),
        .dut_a(a_v[1]), .dut_b(b_v[1]), .dut_y(y_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_count(err_v[1]), .fail_valid(fv_v[1]), .fail_vec(vec_v[1]));

    gate2_bist #(.SETTLE_CYCLES(0), .PASSES(1), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .func_sel(func_sel),
        .dut_a(a_v[2]), .dut_b(b_v[2]), .dut_y(y_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_count(err_v[2]), .fail_valid(fv_v[2]), .fail_vec(vec_v[2]));

    gate2_bist #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(3)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .func_sel(func_sel),
        .dut_a(a_v[3]), .dut_b(b_v[3]), .dut_y(y_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .pass(pass_v[3]), .err_count(err_v[3]), .fail_valid(fv_v[3]), .fail_vec(vec_v[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start a run, scramble func_sel after the start edge, wait (bounded) for done.
    task automatic run(input int inst, input logic [1:0] mode, input logic [2:0] sel,
                       input int exp_lat, input int spur1, input int spur2);
        int lat;
        mode_v[inst]  = mode;
        func_sel      = sel;
        start_v[inst] = 1'b1;
        tick();
        start_v[inst] = 1'b0;
        func_sel      = ~sel;
        ab_log[0]     = {a_v[inst], b_v[inst]};
        chk("busy_after_start", busy_v[inst], 1);
        chk("done_clear_on_start", done_v[inst], 0);
        chk("err_clear_on_start", err_v[inst], 0);
        chk("fv_clear_on_start", fv_v[inst], 0);
        lat = 0;
        while (!done_v[inst] && lat < exp_lat + 20) begin
            start_v[inst] = ((lat + 1) == spur1) || ((lat + 1) == spur2);
            tick();
            start_v[inst] = 1'b0;
            lat++;
            if (lat < 64) ab_log[lat] = {a_v[inst], b_v[inst]};
        end
        chk("done_latency", lat, exp_lat);
        chk("busy_in_done", busy_v[inst], 0);
        chk("ab_zero_in_done", {a_v[inst], b_v[inst]}, 0);
    endtask

    task automatic chk_res(input int inst, input logic [2:0] err, input logic fv,
                           input logic [2:0] vec, input logic ps);
        chk("done", done_v[inst], 1);
        chk("pass", pass_v[inst], ps);
        chk("err_count", err_v[inst], err);
        chk("fail_valid", fv_v[inst], fv);
        chk("fail_vec", vec_v[inst], vec);
    endtask

    task automatic chk_all_zero(input int inst);
        chk("rst_busy", busy_v[inst], 0);
        chk("rst_done", done_v[inst], 0);
        chk("rst_pass", pass_v[inst], 0);
        chk("rst_err", err_v[inst], 0);
        chk("rst_fv", fv_v[inst], 0);
        chk("rst_vec", vec_v[inst], 0);
        chk("rst_ab", {a_v[inst], b_v[inst]}, 0);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [2:0] sel;
        logic [2:0] err;
        logic       fv;
        logic [2:0] vec;
        logic       ps;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{2'd0, 3'd1, 3'd0, 1'b0, 3'b000, 1'b1}; // OR vs OR
        tbl[1]  = '{2'd1, 3'd1, 3'd3, 1'b1, 3'b010, 1'b0}; // stuck-0 vs OR
        tbl[2]  = '{2'd0, 3'd0, 3'd2, 1'b1, 3'b011, 1'b0}; // OR vs AND
        tbl[3]  = '{2'd0, 3'd2, 3'd1, 1'b1, 3'b111, 1'b0}; // OR vs XOR
        tbl[4]  = '{2'd0, 3'd3, 3'd2, 1'b1, 3'b000, 1'b0}; // OR vs NAND
        tbl[5]  = '{2'd0, 3'd4, 3'd4, 1'b1, 3'b000, 1'b0}; // OR vs NOR
        tbl[6]  = '{2'd0, 3'd5, 3'd3, 1'b1, 3'b000, 1'b0}; // OR vs XNOR
        tbl[7]  = '{2'd0, 3'd6, 3'd1, 1'b1, 3'b011, 1'b0}; // OR vs BUF(a)
        tbl[8]  = '{2'd0, 3'd7, 3'd3, 1'b1, 3'b000, 1'b0}; // OR vs NOT(a)
        tbl[9]  = '{2'd2, 3'd1, 3'd1, 1'b1, 3'b001, 1'b0}; // stuck-1 vs OR
        tbl[10] = '{2'd3, 3'd2, 3'd0, 1'b0, 3'b000, 1'b1}; // XOR vs XOR

        rst      = 1'b1;
        start_v  = '0;
        func_sel = 3'd0;
        for (int i = 0; i < 4; i++) mode_v[i] = 2'd0;
        tick();
        tick();
        chk_all_zero(0);
        chk_all_zero(3);
        rst = 1'b0;
        tick();

        // stimulus ordering and per-pattern hold
        run(0, 2'd0, 3'd1, 8, -1, -1);
        chk_res(0, 3'd0, 1'b0, 3'b000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp_ab;
            exp_ab = 2'(k / 2);
            chk($sformatf("ab_seq[%0d]", k), ab_log[k], exp_ab);
        end

        for (int t = 0; t < 11; t++) begin
            run(0, tbl[t].mode, tbl[t].sel, 8, -1, -1);
            chk_res(0, tbl[t].err, tbl[t].fv, tbl[t].vec, tbl[t].ps);
        end

        // start pulses while busy are ignored; back-to-back restart reproduces results
        run(0, 2'd1, 3'd1, 8, 3, 5);
        chk_res(0, 3'd3, 1'b1, 3'b010, 1'b0);
        run(0, 2'd1, 3'd1, 8, -1, -1);
        chk_res(0, 3'd3, 1'b1, 3'b010, 1'b0);

        // four passes: saturation and first-failure hold
        run(1, 2'd1, 3'd1, 32, -1, -1);
        chk_res(1, 3'd7, 1'b1, 3'b010, 1'b0);
        run(1, 2'd0, 3'd1, 32, -1, -1);
        chk_res(1, 3'd0, 1'b0, 3'b000, 1'b1);

        // zero and two settle cycles
        run(2, 2'd0, 3'd1, 4, -1, -1);
        chk_res(2, 3'd0, 1'b0, 3'b000, 1'b1);
        run(2, 2'd1, 3'd1, 4, -1, -1);
        chk_res(2, 3'd3, 1'b1, 3'b010, 1'b0);
        run(3, 2'd0, 3'd0, 12, -1, -1);
        chk_res(3, 3'd2, 1'b1, 3'b011, 1'b0);

        // reset mid-run after a mismatch has been recorded
        mode_v[0]  = 2'd2;
        func_sel   = 3'd1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("err_before_rst", err_v[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero(0);
        repeat (10) tick();
        chk("no_done_after_abort", done_v[0], 0);
        chk("idle_after_abort", busy_v[0], 0);
        run(0, 2'd0, 3'd1, 8, -1, -1);
        chk_res(0, 3'd0, 1'b0, 3'b000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
